// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan controller: digit count,
// blank pattern and the active-low segment codes ({g,f,e,d,c,b,a}).
package seg_pkg;

    localparam int unsigned N_DIGITS = 4;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

endpackage

// File: rtl/hex7seg_dec.sv
// Combinational hex nibble to active-low 7-segment decoder.
module hex7seg_dec
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Table lookup of the segment pattern for one hex digit
    always_comb begin
        seg = SEG_BLANK;
        unique case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// 4-digit common-anode display scanner. Divides clk to a per-digit tick,
// rotates the active-low digit enables and takes new display values through
// a one-deep pending slot that is only committed at a frame boundary.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned DIV_CNT = 25000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    output logic        ready,
    input  logic [3:0]  blank_mask,
    input  logic [3:0]  dp_mask,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp_n
);

    localparam int unsigned CW = $clog2(DIV_CNT);

    logic [CW-1:0] div_cnt;
    logic [1:0]    idx;
    logic [15:0]   disp;
    logic [15:0]   pending;
    logic          pend_valid;

    logic          tick;
    logic          boundary;
    logic          commit;
    logic [1:0]    idx_nxt;
    logic [15:0]   src;
    logic [3:0]    nibble;
    logic [6:0]    seg_dec;

    // Tick, frame boundary and next digit selection
    always_comb begin
        tick     = (div_cnt == CW'(DIV_CNT - 1));
        boundary = tick && (idx == 2'(N_DIGITS - 1));
        commit   = boundary && pend_valid;
        idx_nxt  = (idx == 2'(N_DIGITS - 1)) ? 2'd0 : idx + 2'd1;
        // On a committing boundary digit 0 is decoded straight from the
        // pending value so the whole new frame shows the new digits.
        src      = commit ? pending : disp;
        nibble   = src[{idx_nxt, 2'b00} +: 4];
        ready    = ~pend_valid;
    end

    hex7seg_dec u_dec (
        .nibble (nibble),
        .seg    (seg_dec)
    );

    // Divider, scan position, write slot and registered display outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt    <= '0;
            idx        <= 2'd3;
            disp       <= '0;
            pending    <= '0;
            pend_valid <= 1'b0;
            an         <= '1;
            seg        <= SEG_BLANK;
            dp_n       <= 1'b1;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + CW'(1);

            if (tick) begin
                idx <= idx_nxt;
                if (blank_mask[idx_nxt]) begin
                    an   <= '1;
                    seg  <= SEG_BLANK;
                    dp_n <= 1'b1;
                end else begin
                    an   <= ~(4'b0001 << idx_nxt);
                    seg  <= seg_dec;
                    dp_n <= ~dp_mask[idx_nxt];
                end
            end

            // Capture and commit are mutually exclusive: capture needs an
            // empty slot, commit needs a full one.
            if (wr_en && !pend_valid) begin
                pending    <= wr_data;
                pend_valid <= 1'b1;
            end else if (commit) begin
                disp       <= pending;
                pend_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: directed scenarios plus random
// traffic, compared every cycle against a time-based behavioural model.
module tb_seg_scan_ctrl;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [15:0] wr_data = '0;
    logic        ready;
    logic [3:0]  blank_mask = '0;
    logic [3:0]  dp_mask = '0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp_n;

    int n_checks = 0;
    int n_errors = 0;

    logic [6:0] dec_tbl [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // model state
    int          m_t = 0;
    logic [15:0] m_disp = '0;
    logic [15:0] m_pend = '0;
    bit          m_pend_v = 1'b0;
    logic [3:0]  m_an = 4'hF;
    logic [6:0]  m_seg = 7'h7F;
    logic        m_dp = 1'b1;

    seg_scan_ctrl #(.DIV_CNT(DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .ready      (ready),
        .blank_mask (blank_mask),
        .dp_mask    (dp_mask),
        .an         (an),
        .seg        (seg),
        .dp_n       (dp_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s t=%0d got=%h exp=%h", tag, m_t, obs, exp_v);
        end
    endtask

    // One clock: advance the model with the inputs held this cycle, then
    // compare all outputs shortly after the edge.
    task automatic step();
        bit   captured;
        int   digit;
        @(posedge clk);
        if (rst) begin
            m_t = 0; m_disp = '0; m_pend_v = 1'b0;
            m_an = 4'hF; m_seg = 7'h7F; m_dp = 1'b1;
        end else begin
            m_t++;
            captured = wr_en && !m_pend_v;
            if (m_t % DIV == 0) begin
                digit = ((m_t / DIV) - 1) % 4;
                if (digit == 0 && m_pend_v) begin
                    m_disp = m_pend;
                    m_pend_v = 1'b0;
                end
                if (blank_mask[digit]) begin
                    m_an = 4'hF; m_seg = 7'h7F; m_dp = 1'b1;
                end else begin
                    m_an  = 4'hF & ~(4'(1) << digit);
                    m_seg = dec_tbl[(m_disp >> (4 * digit)) & 16'hF];
                    m_dp  = ~dp_mask[digit];
                end
            end
            if (captured) begin
                m_pend = wr_data;
                m_pend_v = 1'b1;
            end
        end
        #1;
        chk("an", 16'(an), 16'(m_an));
        chk("seg", 16'(seg), 16'(m_seg));
        chk("dp_n", 16'(dp_n), 16'(m_dp));
        chk("ready", 16'(ready), 16'(!m_pend_v));
    endtask

    task automatic write(input logic [15:0] d);
        wr_en = 1'b1; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic run_to(input int tt);
        int guard = 0;
        while (m_t != tt && guard < 500) begin
            step();
            guard++;
        end
        chk("run_to_bound", 16'(m_t == tt), 16'd1);
    endtask

    initial begin
        // 1: reset and first write
        rst = 1'b1;
        step();
        chk("rst_an", 16'(an), 16'hF);
        chk("rst_seg", 16'(seg), 16'h7F);
        chk("rst_dp", 16'(dp_n), 16'd1);
        chk("rst_ready", 16'(ready), 16'd1);
        rst = 1'b0;
        write(16'h1234);
        chk("s1_ready_low", 16'(ready), 16'd0);
        run_to(4);
        chk("s1_an0", 16'(an), 16'b1110);
        chk("s1_seg0", 16'(seg), 16'b0011001);
        chk("s1_ready_hi", 16'(ready), 16'd1);
        run_to(8);
        chk("s1_an1", 16'(an), 16'b1101);
        chk("s1_seg1", 16'(seg), 16'b0110000);
        run_to(12);
        chk("s1_an2", 16'(an), 16'b1011);
        chk("s1_seg2", 16'(seg), 16'b0100100);
        run_to(16);
        chk("s1_an3", 16'(an), 16'b0111);
        chk("s1_seg3", 16'(seg), 16'b1111001);
        run_to(20);
        chk("s1_wrap", 16'(an), 16'b1110);

        // 2 and 3: mid-frame write, then an ignored write while full
        run_to(24);
        write(16'hABCD);
        write(16'hFFFF);
        run_to(28);
        chk("s2_seg2_old", 16'(seg), 16'b0100100);
        run_to(32);
        chk("s2_seg3_old", 16'(seg), 16'b1111001);
        run_to(36);
        chk("s2_an0", 16'(an), 16'b1110);
        chk("s2_seg0_new", 16'(seg), 16'b0100001);
        run_to(68);
        chk("s3_keep_d", 16'(seg), 16'b0100001);
        run_to(76 - 4);
        chk("s3_keep_c", 16'(seg), 16'b1000110);

        // 4: blank digit 2, decimal point on digit 0
        blank_mask = 4'b0100; dp_mask = 4'b0001;
        run_to(76);
        chk("s4_blank_an", 16'(an), 16'hF);
        chk("s4_blank_seg", 16'(seg), 16'h7F);
        chk("s4_blank_dp", 16'(dp_n), 16'd1);
        run_to(84);
        chk("s4_dp0", 16'(dp_n), 16'd0);
        blank_mask = '0; dp_mask = '0;

        // 5: reset during digit 2 with a write pending
        write(16'h5678);
        run_to(92);
        chk("s5_pending", 16'(ready), 16'd0);
        rst = 1'b1;
        step();
        chk("s5_rst_an", 16'(an), 16'hF);
        chk("s5_rst_seg", 16'(seg), 16'h7F);
        chk("s5_rst_ready", 16'(ready), 16'd1);
        rst = 1'b0;
        run_to(4);
        chk("s5_an0", 16'(an), 16'b1110);
        chk("s5_seg0", 16'(seg), 16'b1000000);
        run_to(20);
        chk("s5_discarded", 16'(seg), 16'b1000000);

        // 6: decoder sweep over every hex value on all digits
        for (int k = 0; k < 16; k++) begin
            int guard = 0;
            while (m_pend_v && guard < 40) begin
                step();
                guard++;
            end
            chk("s6_ready_bound", 16'(m_pend_v), 16'd0);
            write({4{4'(k)}});
            for (int c = 0; c < 36; c++) step();
            chk("s6_seg", 16'(seg), 16'(dec_tbl[k]));
        end

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            rst        = ($urandom_range(0, 299) == 0);
            wr_en      = ($urandom_range(0, 7) == 0);
            wr_data    = 16'($urandom);
            if ($urandom_range(0, 15) == 0) blank_mask = 4'($urandom);
            if ($urandom_range(0, 15) == 0) dp_mask = 4'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
